// File: rtl/core_isa_pkg.sv
// Shared RV32I decode constants and fetch/branch FSM state type.
package core_isa_pkg;

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StIssue,
    StResolve,
    StTaken
  } state_t;

  // True for the opcodes that need the RESOLVE/TAKEN path.
  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OpBranch) || (op == OpJal);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch resolver: condition evaluation and B/J immediate extraction.
module branch_cmp
  import core_isa_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_taken,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_b_imm;
  logic [31:0] w_j_imm;
  logic        w_is_jal;

  assign w_is_jal = (i_instr[6:0] == OpJal);
  assign w_b_imm  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
  assign w_j_imm  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};

  // Select immediate by opcode and sign-extend to the datapath width.
  always_comb begin
    o_imm = XLEN'($signed(w_is_jal ? w_j_imm : w_b_imm));
  end

  // JAL is unconditional; branches compare by funct3, reserved encodings never take.
  always_comb begin
    o_taken = 1'b0;
    if (w_is_jal) begin
      o_taken = 1'b1;
    end else begin
      case (i_instr[14:12])
        F3Beq:   o_taken = (i_rs1_data == i_rs2_data);
        F3Bne:   o_taken = (i_rs1_data != i_rs2_data);
        F3Blt:   o_taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
        F3Bge:   o_taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
        F3Bltu:  o_taken = (i_rs1_data <  i_rs2_data);
        F3Bgeu:  o_taken = (i_rs1_data >= i_rs2_data);
        default: o_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fetch_branch_ctrl.sv
// Fetch/branch sequencer: fetches one instruction at a time, resolves
// branch/JAL and steers the external PC register via stall/branchTaken.
module fetch_branch_ctrl
  import core_isa_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_valid,
  input  logic [31:0]     i_imem_data,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_reg_ready,
  output logic [31:0]     o_instr_out,
  output logic            o_instr_valid,
  output logic            o_branch_taken,
  output logic [XLEN-1:0] o_branch_pc_offset,
  output logic            o_stall,
  output logic            o_fetch_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_ir;
  logic [31:0]       w_ir_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_next;
  logic              r_fetch_err;
  logic              w_fetch_err_next;
  logic              w_taken;
  logic [XLEN-1:0]   w_imm;

  branch_cmp #(
    .XLEN (XLEN)
  ) u_branch_cmp (
    .i_instr    (r_ir),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .o_taken    (w_taken),
    .o_imm      (w_imm)
  );

  // State, instruction register, timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ir        <= '0;
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ir        <= w_ir_next;
      r_cnt       <= w_cnt_next;
      r_fetch_err <= w_fetch_err_next;
    end
  end

  // Next-state logic; imemValid is only looked at in WAIT so stale responses are dropped.
  always_comb begin
    w_state_next     = r_state;
    w_ir_next        = r_ir;
    w_cnt_next       = r_cnt;
    w_fetch_err_next = r_fetch_err;
    unique case (r_state)
      StIdle:  w_state_next = StFetch;
      StFetch: begin
        w_cnt_next   = '0;
        w_state_next = StWait;
      end
      StWait: begin
        if (i_imem_valid) begin
          w_ir_next    = i_imem_data;
          w_state_next = is_ctrl_op(i_imem_data[6:0]) ? StResolve : StIssue;
        end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
          w_fetch_err_next = 1'b1;
          w_state_next     = StFetch;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StIssue: w_state_next = StFetch;
      StResolve: begin
        // JAL needs no operands; a branch waits for hazard-free registers.
        if (r_ir[6:0] == OpJal) begin
          w_state_next = StTaken;
        end else if (i_reg_ready) begin
          w_state_next = w_taken ? StTaken : StIssue;
        end
      end
      StTaken: w_state_next = StFetch;
      default: w_state_next = StIdle;
    endcase
  end

  // Moore outputs; PC advances only in ISSUE (+4) or TAKEN (+offset).
  always_comb begin
    o_imem_req         = (r_state == StFetch);
    o_imem_addr        = (r_state == StFetch) ? i_pc : '0;
    o_instr_valid      = (r_state == StIssue) || (r_state == StTaken);
    o_stall            = !((r_state == StIssue) || (r_state == StTaken));
    o_branch_taken     = (r_state == StTaken);
    o_branch_pc_offset = (r_state == StTaken) ? w_imm : '0;
    o_rs1_addr         = r_ir[19:15];
    o_rs2_addr         = r_ir[24:20];
    o_instr_out        = r_ir;
    o_fetch_err        = r_fetch_err;
  end

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Bench for fetch_branch_ctrl: PC register + 1-cycle memory environment,
// table-driven vectors, hand sequences for stall/timeout/reset, random phase.
module tb_fetch_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        reg_ready;
  logic [31:0] instr_out;
  logic        instr_valid, branch_taken, stall, fetch_err;
  logic [31:0] branch_off;

  always #5 clk = ~clk;

  fetch_branch_ctrl #(
    .TIMEOUT (8),
    .XLEN    (32)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_pc               (pc),
    .o_imem_req         (imem_req),
    .o_imem_addr        (imem_addr),
    .i_imem_valid       (imem_valid),
    .i_imem_data        (imem_data),
    .o_rs1_addr         (rs1_addr),
    .o_rs2_addr         (rs2_addr),
    .i_rs1_data         (rs1_data),
    .i_rs2_data         (rs2_data),
    .i_reg_ready        (reg_ready),
    .o_instr_out        (instr_out),
    .o_instr_valid      (instr_valid),
    .o_branch_taken     (branch_taken),
    .o_branch_pc_offset (branch_off),
    .o_stall            (stall),
    .o_fetch_err        (fetch_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bit          taken;
    logic [31:0] off;
  } vec_t;

  vec_t        vecs[10];
  bit          pc_load, rnd_mode, withhold, stale;
  logic [31:0] pc_preset;
  logic [31:0] t_instr, t_rs1, t_rs2;
  logic [31:0] f_pc, f_instr, f_rs1, f_rs2;
  int          checks = 0;
  int          errors = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    if (i[6:0] == 7'b1101111)
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic bit ref_taken(input logic [31:0] i, input logic [31:0] a,
                                   input logic [31:0] b);
    if (i[6:0] == 7'b1101111) return 1'b1;
    if (i[6:0] != 7'b1100011) return 1'b0;
    case (i[14:12])
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic gen_random(output logic [31:0] ins, output logic [31:0] a,
                            output logic [31:0] b);
    logic [31:0] r;
    int          kind;
    r    = $urandom;
    kind = $urandom_range(0, 3);
    case (kind)
      0:       ins = {r[31:7], 7'b0010011};
      3:       ins = {r[31:7], 7'b1101111};
      default: ins = {r[31:7], 7'b1100011};
    endcase
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
  endtask

  // ---------------- environment: PC register + 1-cycle instruction memory ----------------
  initial begin : env
    bit          pend, s_taken, s_stall;
    logic [31:0] s_off;
    imem_valid = 1'b0;
    imem_data  = '0;
    rs1_data   = '0;
    rs2_data   = '0;
    pc         = '0;
    forever begin
      @(negedge clk);
      pend    = imem_req;
      s_taken = branch_taken;
      s_stall = stall;
      s_off   = branch_off;
      @(posedge clk);
      #1;
      if (pc_load)      pc = pc_preset;
      else if (s_taken) pc = pc + s_off;
      else if (!s_stall) pc = pc + 32'd4;
      if (pend) begin
        f_pc = pc;
        if (rnd_mode) gen_random(f_instr, f_rs1, f_rs2);
        else begin
          f_instr = t_instr;
          f_rs1   = t_rs1;
          f_rs2   = t_rs2;
        end
        rs1_data = f_rs1;
        rs2_data = f_rs2;
      end
      imem_valid = (pend && !withhold) || stale;
      imem_data  = (pend && !withhold) ? f_instr : 32'h0080006F;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chkb({name, " instrValid seen"}, ok, 1'b1);
  endtask

  // Waits for the issue pulse of t_instr and checks it plus the resulting PC.
  task automatic run_one(input string name, input bit exp_taken, input logic [31:0] exp_off);
    bit          ok;
    logic [31:0] exp_pc;
    wait_valid(name, ok);
    if (ok) begin
      chkb({name, " taken"}, branch_taken, exp_taken);
      chk({name, " offset"}, branch_off, exp_taken ? exp_off : 32'd0);
      chk({name, " instr"}, instr_out, t_instr);
      chk({name, " rs1addr"}, {27'd0, rs1_addr}, {27'd0, t_instr[19:15]});
      chk({name, " rs2addr"}, {27'd0, rs2_addr}, {27'd0, t_instr[24:20]});
      chkb({name, " stall low"}, stall, 1'b0);
      exp_pc = f_pc + (exp_taken ? exp_off : 32'd4);
      @(negedge clk);
      chk({name, " pc"}, pc, exp_pc);
      chkb({name, " valid 1 cycle"}, instr_valid, 1'b0);
      chkb({name, " stall back"}, stall, 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit          ok, pc_pend, rt;
    logic [31:0] exp_pc, imm;
    int          issued;

    vecs[0] = '{32'h00500093, 32'd0,        32'd0, 1'b0, 32'd0};        // ADDI
    vecs[1] = '{32'h00208463, 32'd5,        32'd5, 1'b1, 32'd8};        // BEQ taken
    vecs[2] = '{32'h00209463, 32'd5,        32'd5, 1'b0, 32'd0};        // BNE not taken
    vecs[3] = '{32'hFFDFF06F, 32'd0,        32'd0, 1'b1, 32'hFFFFFFFC}; // JAL -4
    vecs[4] = '{32'h0020C463, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd8};        // BLT taken
    vecs[5] = '{32'h0020E463, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0};        // BLTU not
    vecs[6] = '{32'h0020D463, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0};        // BGE not
    vecs[7] = '{32'h0020F463, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd8};        // BGEU taken
    vecs[8] = '{32'h0020A463, 32'd5,        32'd5, 1'b0, 32'd0};        // funct3 010
    vecs[9] = '{32'hFE208EE3, 32'd7,        32'd7, 1'b1, 32'hFFFFFFFC}; // BEQ -4

    rst_n     = 1'b1;
    reg_ready = 1'b1;
    pc_load   = 1'b1;
    pc_preset = 32'd0;
    rnd_mode  = 1'b0;
    withhold  = 1'b0;
    stale     = 1'b0;
    t_instr   = '0;
    t_rs1     = '0;
    t_rs2     = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chkb("rst stall", stall, 1'b1);
    chkb("rst req", imem_req, 1'b0);
    chk("rst addr", imem_addr, 32'd0);
    chkb("rst valid", instr_valid, 1'b0);
    chkb("rst taken", branch_taken, 1'b0);
    chk("rst offset", branch_off, 32'd0);
    chkb("rst ferr", fetch_err, 1'b0);
    chk("rst ir", instr_out, 32'd0);

    rst_n   = 1'b1;
    pc_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      t_instr = vecs[i].instr;
      t_rs1   = vecs[i].rs1;
      t_rs2   = vecs[i].rs2;
      if (i == 0) begin
        @(negedge clk);
        chkb("first req", imem_req, 1'b1);
        chk("first addr", imem_addr, 32'd0);
      end
      run_one($sformatf("vec%0d", i), vecs[i].taken, vecs[i].off);
    end

    // regReady held low in RESOLVE: stall stays high, no redirect until release.
    reg_ready = 1'b0;
    t_instr   = 32'h00208463;
    t_rs1     = 32'd9;
    t_rs2     = 32'd9;
    ok        = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (instr_out == 32'h00208463) begin
        ok = 1'b1;
        break;
      end
    end
    chkb("hold reached resolve", ok, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chkb("hold stall", stall, 1'b1);
      chkb("hold no taken", branch_taken, 1'b0);
      if (k < 3) @(negedge clk);
    end
    reg_ready = 1'b1;
    @(negedge clk);
    chkb("hold release taken", branch_taken, 1'b1);
    chk("hold release offset", branch_off, 32'd8);
    exp_pc = f_pc + 32'd8;
    @(negedge clk);
    chk("hold pc", pc, exp_pc);

    // Withheld response: 8 WAIT cycles, then sticky error and a new request.
    withhold = 1'b1;
    t_instr  = 32'h00500093;
    chkb("to req0", imem_req, 1'b1);
    chkb("to ferr0", fetch_err, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chkb($sformatf("to wait%0d req", k), imem_req, 1'b0);
      chkb($sformatf("to wait%0d ferr", k), fetch_err, 1'b0);
    end
    @(negedge clk);
    chkb("to re-req", imem_req, 1'b1);
    chkb("to ferr set", fetch_err, 1'b1);
    withhold = 1'b0;
    run_one("to recover", 1'b0, 32'd0);
    chkb("to ferr sticky", fetch_err, 1'b1);

    // Asynchronous reset mid-WAIT, with stale valid during reset/IDLE/FETCH.
    withhold = 1'b1;
    @(posedge clk);
    #3;
    stale     = 1'b1;
    pc_preset = 32'h40;
    pc_load   = 1'b1;
    rst_n     = 1'b0;
    #1;
    chkb("arst req", imem_req, 1'b0);
    chkb("arst stall", stall, 1'b1);
    chkb("arst ferr", fetch_err, 1'b0);
    chkb("arst valid", instr_valid, 1'b0);
    chk("arst ir", instr_out, 32'd0);
    repeat (2) @(negedge clk);
    chk("arst stale ir", instr_out, 32'd0);
    rst_n    = 1'b1;
    pc_load  = 1'b0;
    withhold = 1'b0;
    t_instr  = 32'h00500093;
    @(negedge clk);
    chkb("arst fetch req", imem_req, 1'b1);
    chk("arst fetch addr", imem_addr, 32'h40);
    chk("arst idle stale ir", instr_out, 32'd0);
    stale = 1'b0;
    run_one("arst issue", 1'b0, 32'd0);
    chkb("arst ferr after", fetch_err, 1'b0);

    // Random phase against the reference model.
    rnd_mode = 1'b1;
    pc_pend  = 1'b0;
    issued   = 0;
    exp_pc   = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reg_ready = ($urandom_range(0, 3) != 0);
      chkb("rnd taken/stall exclusive", branch_taken & stall, 1'b0);
      if (imem_req) chk("rnd addr", imem_addr, pc);
      if (pc_pend) begin
        chk("rnd pc", pc, exp_pc);
        pc_pend = 1'b0;
      end
      if (instr_valid) begin
        rt  = ref_taken(f_instr, f_rs1, f_rs2);
        imm = ref_imm(f_instr);
        chk("rnd instr", instr_out, f_instr);
        chkb("rnd taken", branch_taken, rt);
        chk("rnd offset", branch_off, rt ? imm : 32'd0);
        exp_pc  = f_pc + (rt ? imm : 32'd4);
        pc_pend = 1'b1;
        issued++;
      end
    end
    chkb("rnd progress", issued >= 200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
